lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Multicycle load/store initiator between the core's execute stage and the word-indexed data memory.
- Accepts one byte-addressed load or store, converts it to word-indexed memory accesses, and performs byte-lane extraction with sign/zero extension.
- Implements SB/SH as read-modify-write and flags misaligned, out-of-range or unsupported requests without touching memory.
- Memory side is always issued as a full-word access (mem_func3 = 3'b010).

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the attached data memory; word index >= MEM_WORDS is an access fault.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept a request (IDLE only).
- req_store  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3: loads 000/001/010/100/101, stores 000/001/010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (low byte/half used for SB/SH).
- resp_valid  out  1  one-cycle pulse: request finished.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_err  out  1  valid with resp_valid: misaligned, out-of-range or illegal func3.
- mem_addr  out  32  word index = req_addr[31:2].
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  combinational read data from memory.
- mem_rd  out  1  read enable.
- mem_wr  out  1  write enable (memory writes on posedge).
- mem_func3  out  3  constant 3'b010.

Behaviour:
- Reset: state = IDLE; req_ready = 1; resp_valid = 0; resp_err = 0; resp_rdata = 0; mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0. All captured request registers clear.
- Reset asserted mid-operation:
  - Return to IDLE next edge.
  - No resp_valid is produced.
  - mem_wr deasserts immediately in the reset cycle's following state; a write already sampled on that edge is not undone.
- Handshake:
  - Accept when req_valid && req_ready in IDLE; capture store, func3, addr, wdata.
  - req_ready = 0 in every other state. Inputs are ignored while busy.
- Fault check at accept (combinational on the request inputs):
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: addr[31:2] >= MEM_WORDS.
  - Illegal: load func3 in {011, 110, 111}, or store func3 > 010.
  - On any fault: IDLE -> RESP with resp_err = 1. mem_rd and mem_wr stay 0.
- State transitions:
  - IDLE -> LOAD (load), WRITE (SW), RMW_RD (SB/SH), RESP (fault).
  - LOAD: mem_rd = 1; register the extracted/extended lane from mem_rdata; -> RESP.
  - RMW_RD: mem_rd = 1; register the merged word, where only the addressed byte (SB, lane addr[1:0]) or half (SH, lane addr[1]) is replaced from wdata; -> WRITE.
  - WRITE: mem_wr = 1; mem_wdata = wdata for SW, otherwise the merged word; -> RESP.
  - RESP: resp_valid = 1 for exactly one cycle; -> IDLE, with req_ready = 1 in the next cycle.
- Latency from the accept edge:
  - Load / fault: resp_valid in cycle +2 / +1 respectively.
  - SW: cycle +2.
  - SB/SH: cycle +3.
- mem_addr is held stable for the whole LOAD/RMW_RD/WRITE sequence.
- mem_rd and mem_wr are never high together.
- Load extraction: lane shift = addr[1:0]*8.
  - LB/LH sign-extend from bit 7/15 of the lane.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- resp_rdata holds its value until the next response; it is 0 for stores and faults.

Test Plan:
- Reset then idle: rst high 2 cycles -> req_ready = 1, mem_rd = mem_wr = 0, resp_valid = 0.
- SW addr 0x8, wdata 0xDEADBEEF -> cycle +1: mem_wr = 1, mem_addr = 2, mem_wdata = 0xDEADBEEF; cycle +2: resp_valid = 1, resp_err = 0.
- SB addr 0x9, wdata 0x000000AA over word 0xDEADBEEF -> RMW_RD mem_rd = 1; WRITE mem_wdata = 0xDEADAAEF; then LB 0x9 -> resp_rdata = 0xFFFFFFAA and LBU 0x9 -> 0x000000AA.
- LH 0xA on word 0x8001_1234 -> resp_rdata = 0xFFFF8001; LHU 0xA -> 0x00008001; LW 0x8 -> 0x80011234.
- Faults, each giving resp_valid at +1 with resp_err = 1 and no mem_rd/mem_wr pulse:
  - LW 0x6 (misaligned).
  - SH 0x3 (misaligned).
  - LW 0x80 with MEM_WORDS = 32 (out of range).
  - Load func3 011 (illegal).
- Back-to-back and reset mid-op:
  - req_valid held high across an SB -> second request accepted only after RESP, and no overlapping mem strobes.
  - rst pulsed during RMW_RD -> no mem_wr and no resp_valid; IDLE next cycle.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multicycle byte-addressed load/store initiator for a word-indexed data memory
`timescale 1ns/1ps
module lsu_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  mem_func3
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        misaligned, out_of_range, illegal, fault;
  logic [31:0] lane, load_ext, mask, merge_data, merged;
  assign misaligned   = (req_func3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;
  assign illegal      = req_store ? (req_func3 > 3'b010) : (req_func3 == 3'b011 || req_func3[2:1] == 2'b11);
  assign fault        = misaligned || out_of_range || illegal;
  assign lane     = mem_rdata >> {addr_q[1:0], 3'b000};
  assign load_ext = func3_q == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                    func3_q == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
                    func3_q == 3'b100 ? {24'h0, lane[7:0]} :
                    func3_q == 3'b101 ? {16'h0, lane[15:0]} : lane;
  assign mask       = func3_q[0] ? 32'h0000_FFFF << {addr_q[1], 4'b0000} : 32'h0000_00FF << {addr_q[1:0], 3'b000};
  assign merge_data = func3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  assign merged     = (mem_rdata & ~mask) | (merge_data & mask);
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;
  assign mem_rd     = state_q == LOAD || state_q == RMW_RD;
  assign mem_wr     = state_q == WRITE;
  assign mem_addr   = {2'b00, addr_q[31:2]};
  assign mem_wdata  = mem_wr ? (func3_q[1] ? wdata_q : merged_q) : 32'h0;
  assign mem_func3  = 3'b010;
  // sequence one request; result data only changes on the transition into RESP
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    func3_d  = func3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        store_d = req_store;
        func3_d = req_func3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        err_d   = fault;
        rdata_d = fault ? 32'h0 : rdata_q;
        state_d = fault ? RESP : !req_store ? LOAD : req_func3 == 3'b010 ? WRITE : RMW_RD;
      end
      LOAD: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      RMW_RD: begin
        merged_d = merged;
        state_d  = WRITE;
      end
      WRITE: begin
        rdata_d = 32'h0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and captured request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      func3_q  <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      func3_q  <= func3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: vector table, corner sequences and random traffic against a byte-level memory model
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready, req_store = 0;
  logic [2:0]  req_func3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err, mem_rd, mem_wr;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem [32];
  logic [7:0]  ref_b [128];
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_func3(req_func3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_func3(mem_func3)
  );

  assign mem_rdata = mem_addr < 32 ? mem[mem_addr[4:0]] : 32'h0;
  always @(posedge clk) if (mem_wr && mem_addr < 32) mem[mem_addr[4:0]] <= mem_wdata;

  typedef struct {
    bit          st;
    bit [2:0]    f3;
    logic [31:0] a, wd, ed;
    bit          ee;
    int          el;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // byte-array reference: size, alignment, range and legality straight from the ISA rules
  task automatic model(input bit st, input bit [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] d, output bit e, output int lat, output logic [31:0] w);
    int sz;
    sz = f3[1:0] == 0 ? 1 : f3[1:0] == 1 ? 2 : 4;
    e = (st ? f3 > 2 : (f3 == 3 || f3 > 5)) || (a % sz != 0) || (a / 4 >= 32);
    d = 0; w = 0; lat = 1;
    if (!e) begin
      if (st) begin
        for (int i = 0; i < sz; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
        lat = sz == 4 ? 2 : 3;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_b[int'(a / 4) * 4 + i];
      end else begin
        for (int i = 0; i < sz; i++) d[8*i +: 8] = ref_b[int'(a) + i];
        if (!f3[2] && sz < 4 && d[8*sz-1])
          for (int i = sz; i < 4; i++) d[8*i +: 8] = 8'hFF;
        lat = 2;
      end
    end
  endtask

  task automatic exec(input string nm, input bit st, input bit [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] ed, input bit ee, input int el,
                      input logic [31:0] ew);
    int nrd, nwr, lat;
    bit both, e;
    logic [31:0] d, wa, wv;
    nrd = 0; nwr = 0; lat = 0; both = 0; e = 0; d = 0; wa = 0; wv = 0;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1; req_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; req_store = 1'($urandom_range(0, 1)); req_func3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_rd) nrd++;
      if (mem_wr) begin nwr++; wa = mem_addr; wv = mem_wdata; end
      if (mem_rd && mem_wr) both = 1;
      if (resp_valid) begin lat = c; d = resp_rdata; e = resp_err; break; end
    end
    chk({nm, "_lat"}, 32'(lat), 32'(el));
    chk({nm, "_err"}, 32'(e), 32'(ee));
    chk({nm, "_data"}, d, ed);
    chk({nm, "_nrd"}, 32'(nrd), (ee || (st && f3 == 2)) ? 32'd0 : 32'd1);
    chk({nm, "_nwr"}, 32'(nwr), (!ee && st) ? 32'd1 : 32'd0);
    chk({nm, "_overlap"}, 32'(both), 32'd0);
    if (!ee && st) begin
      chk({nm, "_waddr"}, wa, a >> 2);
      chk({nm, "_wdata"}, wv, ew);
    end
  endtask

  initial begin
    logic [31:0] md, mw, md2, mw2;
    bit me, me2;
    int ml, ml2, busy, nres, nwr;
    bit ov;
    for (int i = 0; i < 32; i++) mem[i] = 0;
    for (int i = 0; i < 128; i++) ref_b[i] = 0;
    tbl = '{
      '{1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0, 0, 2},
      '{1, 3'b000, 32'h09, 32'h000000AA, 32'h0, 0, 3},
      '{0, 3'b000, 32'h09, 32'h0, 32'hFFFFFFAA, 0, 2},
      '{0, 3'b100, 32'h09, 32'h0, 32'h000000AA, 0, 2},
      '{1, 3'b010, 32'h08, 32'h80011234, 32'h0, 0, 2},
      '{0, 3'b001, 32'h0A, 32'h0, 32'hFFFF8001, 0, 2},
      '{0, 3'b101, 32'h0A, 32'h0, 32'h00008001, 0, 2},
      '{0, 3'b010, 32'h08, 32'h0, 32'h80011234, 0, 2},
      '{0, 3'b010, 32'h06, 32'h0, 32'h0, 1, 1},
      '{1, 3'b001, 32'h03, 32'h1234, 32'h0, 1, 1},
      '{0, 3'b010, 32'h80, 32'h0, 32'h0, 1, 1},
      '{0, 3'b011, 32'h00, 32'h0, 32'h0, 1, 1},
      '{1, 3'b100, 32'h00, 32'h55, 32'h0, 1, 1},
      '{1, 3'b001, 32'h0A, 32'h12345678, 32'h0, 0, 3},
      '{0, 3'b010, 32'h08, 32'h0, 32'h56781234, 0, 2},
      '{0, 3'b000, 32'h0B, 32'h0, 32'h00000056, 0, 2},
      '{0, 3'b001, 32'h08, 32'h0, 32'h00001234, 0, 2},
      '{0, 3'b010, 32'h7C, 32'h0, 32'h00000000, 0, 2}
    };
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);
    chk("mem_func3", 32'(mem_func3), 32'd2);
    for (int i = 0; i < 18; i++) begin
      model(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, md, me, ml, mw);
      exec($sformatf("tbl%0d", i), tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].ed, tbl[i].ee, tbl[i].el, mw);
    end
    // req_valid held high across an SB, with a load queued behind it
    model(1, 3'b000, 32'h11, 32'h77, md, me, ml, mw);
    model(0, 3'b010, 32'h10, 32'h0, md2, me2, ml2, mw2);
    @(negedge clk);
    req_valid = 1; req_store = 1; req_func3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_store = 0; req_func3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    busy = 0; ov = 0; nres = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (!req_ready) busy++;
      if (mem_rd && mem_wr) ov = 1;
      if (resp_valid) nres++;
      if (c == 2) chk("b2b_sb_wdata", mem_wdata, mw);
    end
    chk("b2b_busy", 32'(busy), 32'd3);
    chk("b2b_sb_resp", 32'(nres), 32'd1);
    @(negedge clk);
    chk("b2b_ready_again", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
    nres = 0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (mem_rd && mem_wr) ov = 1;
      if (resp_valid) begin nres++; chk("b2b_lw_data", resp_rdata, md2); end
    end
    chk("b2b_lw_resp", 32'(nres), 32'd1);
    chk("b2b_overlap", 32'(ov), 32'd0);
    // reset during RMW_RD: no write, no response, memory untouched
    @(negedge clk);
    req_valid = 1; req_store = 1; req_func3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk("rstmid_rd", 32'(mem_rd), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    nwr = 0; nres = 0;
    for (int c = 0; c < 3; c++) begin
      if (mem_wr) nwr++;
      if (resp_valid) nres++;
      @(negedge clk);
    end
    chk("rstmid_nwr", 32'(nwr), 32'd0);
    chk("rstmid_nresp", 32'(nres), 32'd0);
    model(0, 3'b010, 32'h20, 32'h0, md, me, ml, mw);
    exec("rstmid_lw", 0, 3'b010, 32'h20, 32'h0, md, me, ml, mw);
    // random traffic against the model
    for (int i = 0; i < 150; i++) begin
      bit st;
      bit [2:0] f3;
      logic [31:0] a, wd;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 9) == 0 ? $urandom_range(128, 255) : $urandom_range(0, 127);
      wd = $urandom;
      model(st, f3, a, wd, md, me, ml, mw);
      exec($sformatf("rnd%0d", i), st, f3, a, wd, md, me, ml, mw);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
